tgen_tx_serializer: RTL

Periph-clock-domain serializer for the traffic-generator TX path. It takes 32-bit words from the post-CDC FIFO over a valid/ready handshake and shifts them onto 1, 2, 4 or 8 pad lanes. It generates a forwarded pad clock, a word strobe and completion events. Compared with the fixed 4-lane, fixed-rate generator, it adds a selectable lane count, bit order, clock divider, back-to-back streaming and idle-level control.

---
 rtl/tgen_tx_serializer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tgen_tx_serializer.sv
// tgen_tx_serializer
//   Periph-clock-domain TX serializer for the traffic generator. Accepts
//   WORD_W-bit words from the post-CDC FIFO over valid/ready. It shifts each
//   word onto 1..MAX_LANES pad lanes using a programmable beat length, and
//   forwards a pad clock and a word strobe with the data.
//
// Ports
//   periph_clk_i      peripheral clock
//   rstn_i            async reset, active low
//   cfg_en_i          serializer enable
//   cfg_lanes_i       active lanes = 1<<cfg_lanes_i (clamped to MAX_LANES)
//   cfg_msb_first_i   1 = MSB slice first, 0 = LSB slice first
//   cfg_clkdiv_i      beat length = max(cfg_clkdiv_i,1)+1 cycles
//   cfg_idle_hold_i   1 = hold last beat on pads in idle, 0 = drive 0
//   data_i/valid_i    word from CDC FIFO
//   ready_o           word accepted when valid_i & ready_o
//   pad_data_o        lane data
//   pad_data_oe_o     lane output enables
//   pad_clk_o         forwarded clock (rises mid-beat)
//   pad_wrd_o         high during the first beat of every word
//   busy_o            word in flight
//   word_done_o       1-cycle pulse on the last cycle of each word
module tgen_tx_serializer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MAX_LANES = 8,
  parameter int unsigned CLKDIV_W  = 8
) (
  input  logic                 periph_clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [1:0]           cfg_lanes_i,
  input  logic                 cfg_msb_first_i,
  input  logic [CLKDIV_W-1:0]  cfg_clkdiv_i,
  input  logic                 cfg_idle_hold_i,
  input  logic [WORD_W-1:0]    data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [MAX_LANES-1:0] pad_data_o,
  output logic [MAX_LANES-1:0] pad_data_oe_o,
  output logic                 pad_clk_o,
  output logic                 pad_wrd_o,
  output logic                 busy_o,
  output logic                 word_done_o
);

  localparam int unsigned LOG_MAX = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 0;
  localparam int unsigned KW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_n;
  logic [WORD_W-1:0]    sh_q, sh_n;
  logic [KW-1:0]        k_q, k_n;
  logic [CLKDIV_W-1:0]  d_q, d_n;
  logic [CLKDIV_W-1:0]  div_q, div_n;
  logic [1:0]           lanes_q, lanes_n;
  logic                 msb_q, msb_n;
  logic                 hold_q, hold_n;
  logic                 oe_en_q, oe_en_n;

  logic [1:0]           cfg_lanes_clamped;
  logic [CLKDIV_W-1:0]  cfg_div_eff;
  logic                 beat_end, last_beat, load;
  logic [WORD_W-1:0]    slice_src;
  logic [MAX_LANES-1:0] mask_n, slice_n;

  assign cfg_lanes_clamped = (32'(cfg_lanes_i) > LOG_MAX) ? 2'(LOG_MAX) : cfg_lanes_i;
  assign cfg_div_eff       = (cfg_clkdiv_i == '0) ? CLKDIV_W'(1) : cfg_clkdiv_i;

  assign beat_end  = (d_q == div_q);
  assign last_beat = (k_q == KW'((WORD_W >> lanes_q) - 1));

  assign busy_o      = (state_q == SHIFT);
  assign word_done_o = (state_q == SHIFT) && beat_end && last_beat;
  // Gated by rstn_i so that every output reads 0 while reset is held.
  assign ready_o     = rstn_i && ((state_q == IDLE) ? cfg_en_i
                                                    : (beat_end && last_beat && cfg_en_i));
  assign load        = valid_i && ready_o;

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      k_q     <= '0;
      d_q     <= '0;
      div_q   <= '0;
      lanes_q <= '0;
      msb_q   <= 1'b0;
      hold_q  <= 1'b0;
      oe_en_q <= 1'b0;
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      k_q     <= k_n;
      d_q     <= d_n;
      div_q   <= div_n;
      lanes_q <= lanes_n;
      msb_q   <= msb_n;
      hold_q  <= hold_n;
      oe_en_q <= oe_en_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    k_n     = k_q;
    d_n     = d_q;
    div_n   = div_q;
    lanes_n = lanes_q;
    msb_n   = msb_q;
    hold_n  = hold_q;
    oe_en_n = oe_en_q;

    unique case (state_q)
      IDLE: begin
        if (!cfg_en_i) oe_en_n = 1'b0;
      end
      SHIFT: begin
        if (beat_end) begin
          d_n = '0;
          if (last_beat) begin
            if (!load) begin
              state_n = IDLE;
              if (!cfg_en_i) oe_en_n = 1'b0;
            end
          end else begin
            k_n  = k_q + 1'b1;
            sh_n = msb_q ? (sh_q << (32'd1 << lanes_q)) : (sh_q >> (32'd1 << lanes_q));
          end
        end else begin
          d_n = d_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      state_n = SHIFT;
      sh_n    = data_i;
      k_n     = '0;
      d_n     = '0;
      div_n   = cfg_div_eff;
      lanes_n = cfg_lanes_clamped;
      msb_n   = cfg_msb_first_i;
      hold_n  = cfg_idle_hold_i;
      oe_en_n = 1'b1;
    end
  end

  // The current beat always sits at the top (MSB-first) or bottom (LSB-first)
  // of the shift register, so the lane slice is a fixed-position extract.
  always_comb begin
    slice_src = msb_n ? (sh_n >> (WORD_W - (32'd1 << lanes_n))) : sh_n;
    mask_n    = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      mask_n[i] = (i < (32'd1 << lanes_n));
    end
    slice_n = slice_src[MAX_LANES-1:0] & mask_n;
  end

  // Pads are registered from the next-state values, so a beat reaches the
  // pads in the same cycle the internal beat/divider state shows it. The
  // first beat therefore appears one cycle after the accepting handshake.
  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pad_data_o    <= '0;
      pad_data_oe_o <= '0;
      pad_clk_o     <= 1'b0;
      pad_wrd_o     <= 1'b0;
    end else begin
      pad_data_oe_o <= oe_en_n ? mask_n : '0;
      if (state_n == SHIFT) begin
        pad_data_o <= slice_n;
        pad_wrd_o  <= (k_n == '0);
        pad_clk_o  <= (d_n > (div_n >> 1));
      end else begin
        pad_data_o <= hold_n ? pad_data_o : '0;
        pad_wrd_o  <= 1'b0;
        pad_clk_o  <= 1'b0;
      end
    end
  end

endmodule
